prog_loader_ctrl: RTL and testbench
===================================

# prog_loader_ctrl

Boot/run sequencer between a host streaming interface and the unified CPU system. It accepts a program as a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into the 32-entry program memory. It then raises the CPU start when the host requests execution, and supervises the run until the CPU halts, leaves the loaded program, or exceeds a cycle budget. It replaces hand-driven `prog_addr`/`prog_write_enable`/`start_execution` sequencing.

## Interface
- `DATA_WIDTH`, 16, instruction word width
- `ADDR_WIDTH`, 5, program memory address width; depth = 2**ADDR_WIDTH = 32
- `MAX_RUN_CYCLES`, 1024, run-phase cycle budget before timeout (≥2, ≤65535)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low; the block is reset at a rising edge where `reset`=0
- `host_valid` in 1: host word valid
- `host_ready` out 1: block can accept a word
- `host_data` in DATA_WIDTH: instruction or checksum word
- `host_last` in 1: final program word of this beat
- `host_go` in 1: request execution (sampled in LOADED only)
- `host_clear` in 1: abort/acknowledge; return to IDLE
- `mem_we` out 1: program memory write strobe
- `mem_addr` out ADDR_WIDTH: write address
- `mem_wdata` out DATA_WIDTH: write data
- `cpu_start` out 1: level; held high for the whole RUN state
- `cpu_halt` in 1: CPU reports halt
- `cpu_pc` in ADDR_WIDTH: CPU program counter
- `load_done` out 1: program resident, awaiting `host_go`
- `run_done` out 1: run finished normally
- `error` out 1: ERR state
- `err_code` out 2: 01 overflow, 10 timeout, 11 checksum mismatch, 00 none
- `word_count` out ADDR_WIDTH+1: words written in the current load
- `run_cycles` out 16: cycles spent in RUN, frozen on exit

## Operation
- States: IDLE, LOAD, CHECK, LOADED, RUN, DONE, ERR.
- A beat is accepted when `host_valid & host_ready` at a clock edge. `host_ready`=1 in IDLE/LOAD/CHECK, else 0.
- IDLE/LOAD accepted beat: write `host_data` at address `word_count`, then increment `word_count`. IDLE clears `word_count` to 0 before its first write.
  - `host_last`=1 → CHECK if the macro is defined, else LOADED.
  - `host_last`=0 at address 31 → ERR, code 01. The word at address 31 is still written.
  - Otherwise → LOAD.
- CHECK: see Configuration.
- LOADED: `load_done`=1. `host_go`=1 → RUN; clear `run_cycles`.
- RUN: `cpu_start`=1; `run_cycles` increments each cycle. Exit conditions, highest priority first:
  - `cpu_halt`=1 → DONE.
  - `cpu_pc` ≥ `word_count` → DONE.
  - `run_cycles` = MAX_RUN_CYCLES−1 → ERR, code 10.
- DONE: `run_done`=1. `host_go`=1 → RUN again, same program, `run_cycles` cleared.
- ERR: `error`=1; `err_code` holds its value.
- `host_clear`=1 in any state → IDLE. It overrides every other transition; only reset ranks above it. It clears `err_code`, `run_done`, `load_done`, and `cpu_start`.
- Reset values: state IDLE; every output 0 except `host_ready`=1; all counters 0.
- Reset mid-load or mid-run aborts immediately. Words already written remain in memory and are unspecified for reuse.

## Timing
- `mem_we`/`mem_addr`/`mem_wdata` are registered. The beat accepted at edge N drives the write strobe during cycle N+1, and memory captures it at edge N+1.
- Back-to-back beats sustain 1 word/cycle.
- `load_done` rises in the same cycle as the last word's `mem_we`, i.e. at edge N following acceptance at edge N.
- `cpu_start` rises one edge after `host_go` is sampled in LOADED, so the earliest start is 2 cycles after the last beat. This guarantees the final write has completed.
- `cpu_start` falls at the edge of the RUN→DONE or RUN→ERR transition.
- All status outputs are registered and change only at clock edges.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A 16-bit running XOR of all written words is kept.
  - After the `host_last` beat, the block is in CHECK and expects one more beat, which is not written to memory.
  - Beat equal to the XOR → LOADED; otherwise → ERR, code 11.
- `LOADER_CHECKSUM_EN` undefined: no accumulator; CHECK is unreachable; `host_last` goes straight to LOADED.
- The port list is identical in both builds.

## Test plan
- Hold `reset`=0 for 2 cycles → `host_ready`=1; `load_done`, `cpu_start`, `error`, `mem_we` = 0; `word_count`=0.
- Stream 0x8101, 0x8901, 0x0120 back-to-back, `host_last` on the third (checksum macro off) → writes to addresses 0, 1, 2 on consecutive cycles; `word_count`=3; `load_done`=1.
- From LOADED, pulse `host_go`, then assert `cpu_halt` on the 5th RUN cycle → `cpu_start` high for exactly 5 cycles; `run_done`=1; `run_cycles`=5.
- Send 32 words with `host_last`=0 → ERR, `err_code`=01; `host_ready`=0; a 33rd beat is not accepted. Then `host_clear` → IDLE.
- `MAX_RUN_CYCLES`=8, `cpu_halt`=0, `cpu_pc`=0 → ERR, code 10, after 8 RUN cycles. A separate case with `cpu_pc` reaching `word_count` → DONE.
- Macro on: load 0x1234, 0x00FF(last), then checksum 0x12CB → LOADED. Repeat with checksum 0x0000 → ERR, code 11. Assert `reset` mid-RUN → IDLE with `cpu_start`=0 next cycle.

Source files
------------

// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl
//   Boot/run sequencer between a host word stream and the CPU system.
//   Streams instruction words into program memory, waits for host_go, then
//   holds cpu_start high while supervising the run for halt, PC escape or
//   cycle-budget timeout.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a running XOR of all written words is kept and one extra
//     checksum beat is expected after the host_last beat (state CHECK).
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-low reset
//   host_valid/ready   word handshake; host_data word, host_last final word
//   host_go            start (or restart) execution from LOADED/DONE
//   host_clear         abort/acknowledge, back to IDLE from any state
//   mem_we/addr/wdata  registered program memory write port
//   cpu_start          level, high throughout RUN
//   cpu_halt, cpu_pc   CPU run status
//   load_done, run_done, error, err_code   status
//   word_count         words written in the current load
//   run_cycles         cycles spent in RUN, frozen on exit
module prog_loader_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 5,
   parameter int MAX_RUN_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic [DATA_WIDTH-1:0] host_data,
   input  logic                  host_last,
   input  logic                  host_go,
   input  logic                  host_clear,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_start,
   input  logic                  cpu_halt,
   input  logic [ADDR_WIDTH-1:0] cpu_pc,
   output logic                  load_done,
   output logic                  run_done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [15:0]           run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_LOADED, S_RUN, S_DONE, S_ERR
   } state_t;

   localparam logic [1:0]          ERR_NONE     = 2'b00;
   localparam logic [1:0]          ERR_OVERFLOW = 2'b01;
   localparam logic [1:0]          ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0]          ERR_CHECKSUM = 2'b11;
   localparam logic [15:0]         RUN_LIMIT    = 16'(MAX_RUN_CYCLES - 1);
   localparam logic [ADDR_WIDTH:0] WC_ONE       = 1;

   state_t                state_q, state_d;
   logic [1:0]            err_d;
   logic                  accept;
   logic                  wr_fire;
   logic                  at_top;
   logic                  pc_out;
   logic [ADDR_WIDTH-1:0] wr_addr;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;
   logic [DATA_WIDTH-1:0] sum_next;
`endif

   // Status outputs are plain decodes of the state register, so they only
   // move at clock edges.
   assign host_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CHECK);
   assign load_done  = (state_q == S_LOADED);
   assign run_done   = (state_q == S_DONE);
   assign cpu_start  = (state_q == S_RUN);
   assign error      = (state_q == S_ERR);

   assign accept  = host_valid & host_ready;
   // IDLE always starts a fresh load at address 0.
   assign wr_addr = (state_q == S_IDLE) ? '0 : word_count[ADDR_WIDTH-1:0];
   assign at_top  = &wr_addr;
   // A clear in the same cycle wins over the beat, so nothing is written.
   assign wr_fire = accept & ~host_clear & ((state_q == S_IDLE) || (state_q == S_LOAD));
   assign pc_out  = ({1'b0, cpu_pc} >= word_count);

`ifdef LOADER_CHECKSUM_EN
   assign sum_next = (state_q == S_IDLE) ? host_data : (sum_q ^ host_data);
`endif

   always_comb begin
      state_d = state_q;
      err_d   = err_code;
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               if (host_last) begin
`ifdef LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_LOADED;
`endif
               end else if (at_top) begin
                  // Last slot is still written; the stream simply has no room left.
                  state_d = S_ERR;
                  err_d   = ERR_OVERFLOW;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) begin
               if (host_data == sum_q) begin
                  state_d = S_LOADED;
               end else begin
                  state_d = S_ERR;
                  err_d   = ERR_CHECKSUM;
               end
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_LOADED, S_DONE: begin
            if (host_go) state_d = S_RUN;
         end
         S_RUN: begin
            if (cpu_halt || pc_out) begin
               state_d = S_DONE;
            end else if (run_cycles == RUN_LIMIT) begin
               state_d = S_ERR;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
      if (host_clear) begin
         state_d = S_IDLE;
         err_d   = ERR_NONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         err_code   <= ERR_NONE;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         run_cycles <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         err_code <= err_d;
         mem_we   <= wr_fire;
         if (wr_fire) begin
            mem_addr   <= wr_addr;
            mem_wdata  <= host_data;
            word_count <= {1'b0, wr_addr} + WC_ONE;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_next;
`endif
         end else if (host_clear) begin
            word_count <= '0;
         end
         // Cleared on entry to RUN, counts every RUN edge including the exit edge.
         if (state_q == S_RUN)
            run_cycles <= run_cycles + 16'd1;
         else if (state_d == S_RUN)
            run_cycles <= '0;
      end
   end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
module tb_prog_loader_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        host_valid = 1'b0, host_last = 1'b0, host_go = 1'b0, host_clear = 1'b0;
   logic [15:0] host_data = '0;
   logic        host_ready;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_start;
   logic        cpu_halt = 1'b0;
   logic [4:0]  cpu_pc = '0;
   logic        load_done, run_done, error;
   logic [1:0]  err_code;
   logic [5:0]  word_count;
   logic [15:0] run_cycles;

   int errors = 0;
   int checks = 0;

   prog_loader_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .MAX_RUN_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
      .host_last(host_last), .host_go(host_go), .host_clear(host_clear),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_start(cpu_start), .cpu_halt(cpu_halt), .cpu_pc(cpu_pc),
      .load_done(load_done), .run_done(run_done), .error(error),
      .err_code(err_code), .word_count(word_count), .run_cycles(run_cycles)
   );

   always #5 clock = ~clock;

   // Advance one edge; outputs are then stable for sampling and inputs can change.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", host_ready); end
      checks++; if ({load_done, run_done, cpu_start, error, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {load_done, run_done, cpu_start, error, mem_we}); end
      checks++; if (word_count !== 6'd0 || err_code !== 2'd0 || run_cycles !== 16'd0) begin errors++; $display("FAIL reset_counters: wc=%0d ec=%0d rc=%0d want 0", word_count, err_code, run_cycles); end
      reset = 1'b1;
   endtask

   task automatic test_load();
      host_valid = 1'b1; host_last = 1'b0; host_data = 16'h8101;
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mem_wdata !== 16'h8101 || word_count !== 6'd1) begin errors++; $display("FAIL load_w0: we=%b a=%0d d=%h wc=%0d want 1 0 8101 1", mem_we, mem_addr, mem_wdata, word_count); end
      host_data = 16'h8901;
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd1 || mem_wdata !== 16'h8901 || word_count !== 6'd2) begin errors++; $display("FAIL load_w1: we=%b a=%0d d=%h wc=%0d want 1 1 8901 2", mem_we, mem_addr, mem_wdata, word_count); end
      host_data = 16'h0120; host_last = 1'b1;
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 5'd2 || mem_wdata !== 16'h0120 || word_count !== 6'd3) begin errors++; $display("FAIL load_w2: we=%b a=%0d d=%h wc=%0d want 1 2 0120 3", mem_we, mem_addr, mem_wdata, word_count); end
`ifdef LOADER_CHECKSUM_EN
      checks++; if (load_done !== 1'b0 || host_ready !== 1'b1) begin errors++; $display("FAIL load_check_state: ld=%b rdy=%b want 0 1", load_done, host_ready); end
      host_last = 1'b0; host_data = 16'h0920;
      tick();
`endif
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done: got %b want 1", load_done); end
      host_valid = 1'b0; host_last = 1'b0;
      tick();
      checks++; if (mem_we !== 1'b0 || host_ready !== 1'b0 || load_done !== 1'b1 || word_count !== 6'd3) begin errors++; $display("FAIL load_idle: we=%b rdy=%b ld=%b wc=%0d want 0 0 1 3", mem_we, host_ready, load_done, word_count); end
   endtask

   task automatic test_run_halt();
      int bad = 0;
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (cpu_start !== 1'b1 || run_cycles !== 16'(k - 1)) bad++;
         if (k == 5) cpu_halt = 1'b1;
         tick();
      end
      cpu_halt = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL halt_run_window: bad cycles=%0d want 0", bad); end
      checks++; if (cpu_start !== 1'b0 || run_done !== 1'b1 || run_cycles !== 16'd5) begin errors++; $display("FAIL halt_done: start=%b done=%b rc=%0d want 0 1 5", cpu_start, run_done, run_cycles); end
      tick();
      checks++; if (run_cycles !== 16'd5 || run_done !== 1'b1) begin errors++; $display("FAIL halt_frozen: rc=%0d done=%b want 5 1", run_cycles, run_done); end
   endtask

   task automatic test_pc_exit();
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      checks++; if (cpu_start !== 1'b1 || run_done !== 1'b0 || run_cycles !== 16'd0) begin errors++; $display("FAIL rerun_start: start=%b done=%b rc=%0d want 1 0 0", cpu_start, run_done, run_cycles); end
      cpu_pc = 5'd2;
      tick();
      checks++; if (cpu_start !== 1'b1 || run_cycles !== 16'd1) begin errors++; $display("FAIL pc_inside: start=%b rc=%0d want 1 1", cpu_start, run_cycles); end
      cpu_pc = 5'd3;
      tick();
      cpu_pc = 5'd0;
      checks++; if (cpu_start !== 1'b0 || run_done !== 1'b1 || error !== 1'b0 || run_cycles !== 16'd2) begin errors++; $display("FAIL pc_exit: start=%b done=%b err=%b rc=%0d want 0 1 0 2", cpu_start, run_done, error, run_cycles); end
   endtask

   task automatic test_timeout();
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      repeat (7) tick();
      checks++; if (cpu_start !== 1'b1 || error !== 1'b0 || run_cycles !== 16'd7) begin errors++; $display("FAIL timeout_cycle8: start=%b err=%b rc=%0d want 1 0 7", cpu_start, error, run_cycles); end
      tick();
      checks++; if (cpu_start !== 1'b0 || error !== 1'b1 || err_code !== 2'b10 || run_cycles !== 16'd8) begin errors++; $display("FAIL timeout_err: start=%b err=%b ec=%b rc=%0d want 0 1 10 8", cpu_start, error, err_code, run_cycles); end
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      checks++; if (error !== 1'b0 || err_code !== 2'b00 || host_ready !== 1'b1 || word_count !== 6'd0) begin errors++; $display("FAIL timeout_clear: err=%b ec=%b rdy=%b wc=%0d want 0 00 1 0", error, err_code, host_ready, word_count); end
   endtask

   task automatic test_overflow();
      int bad = 0;
      host_valid = 1'b1; host_last = 1'b0;
      for (int i = 0; i < 32; i++) begin
         host_data = 16'(16'h0A00 + i);
         tick();
         if (mem_we !== 1'b1 || mem_addr !== 5'(i) || mem_wdata !== 16'(16'h0A00 + i)) bad++;
         if (i < 31 && error !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL ovf_stream: bad beats=%0d want 0", bad); end
      checks++; if (error !== 1'b1 || err_code !== 2'b01 || host_ready !== 1'b0 || word_count !== 6'd32) begin errors++; $display("FAIL ovf_err: err=%b ec=%b rdy=%b wc=%0d want 1 01 0 32", error, err_code, host_ready, word_count); end
      host_data = 16'hDEAD;
      tick();
      checks++; if (mem_we !== 1'b0 || word_count !== 6'd32 || err_code !== 2'b01) begin errors++; $display("FAIL ovf_33rd: we=%b wc=%0d ec=%b want 0 32 01", mem_we, word_count, err_code); end
      host_valid = 1'b0;
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      checks++; if (error !== 1'b0 || err_code !== 2'b00 || host_ready !== 1'b1) begin errors++; $display("FAIL ovf_clear: err=%b ec=%b rdy=%b want 0 00 1", error, err_code, host_ready); end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      host_valid = 1'b1; host_last = 1'b0; host_data = 16'h1234;
      tick();
      host_data = 16'h00FF; host_last = 1'b1;
      tick();
      host_last = 1'b0; host_data = 16'h12CB;
      tick();
      checks++; if (load_done !== 1'b1 || error !== 1'b0 || mem_we !== 1'b0 || word_count !== 6'd2) begin errors++; $display("FAIL csum_good: ld=%b err=%b we=%b wc=%0d want 1 0 0 2", load_done, error, mem_we, word_count); end
      host_valid = 1'b0;
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      host_valid = 1'b1; host_data = 16'h1234;
      tick();
      host_data = 16'h00FF; host_last = 1'b1;
      tick();
      host_last = 1'b0; host_data = 16'h0000;
      tick();
      host_valid = 1'b0;
      checks++; if (error !== 1'b1 || err_code !== 2'b11 || load_done !== 1'b0) begin errors++; $display("FAIL csum_bad: err=%b ec=%b ld=%b want 1 11 0", error, err_code, load_done); end
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_run();
      host_valid = 1'b1; host_last = 1'b1; host_data = 16'h0001;
      tick();
`ifdef LOADER_CHECKSUM_EN
      host_last = 1'b0;
      tick();
`endif
      host_valid = 1'b0; host_last = 1'b0;
      checks++; if (load_done !== 1'b1 || word_count !== 6'd1) begin errors++; $display("FAIL single_load: ld=%b wc=%0d want 1 1", load_done, word_count); end
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      tick();
      checks++; if (cpu_start !== 1'b1 || run_cycles !== 16'd1) begin errors++; $display("FAIL midrun_running: start=%b rc=%0d want 1 1", cpu_start, run_cycles); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (cpu_start !== 1'b0 || host_ready !== 1'b1 || word_count !== 6'd0 || run_cycles !== 16'd0) begin errors++; $display("FAIL midrun_reset: start=%b rdy=%b wc=%0d rc=%0d want 0 1 0 0", cpu_start, host_ready, word_count, run_cycles); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_run_halt();
      test_pc_exit();
      test_timeout();
      test_overflow();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
